// File: rtl/idli_pkg.sv
// Shared types and constants for the idli retire tracer.
package idli_pkg;

  localparam int TRC_DEPTH = 8;
  localparam int NUM_REGS  = 16;
  localparam int DATA_W    = 16;
  localparam int SEQ_W     = 8;
  localparam int DROP_W    = 8;
  localparam int REG_W     = $clog2(NUM_REGS);

  // Sync counter value of the last GCK of an instruction period
  localparam logic [1:0] CTR_LAST = 2'd3;

  // r0 is never reported, so the mask starts at bit 1
  typedef struct packed {
    logic [DATA_W-1:0]   pc;
    logic [NUM_REGS-1:1] reg_mask;
    logic                pred_wr;
    logic                pred_val;
    logic [SEQ_W-1:0]    seq;
    logic                lost;
  } trc_rec_t;

endpackage

// File: rtl/idli_trace_if.sv
// Record drain port: tracer presents a head record, consumer accepts with rdy.
interface idli_trace_if;
  import idli_pkg::*;

  logic     o_trc_vld;
  logic     i_trc_rdy;
  trc_rec_t o_trc_rec;

  modport master (output o_trc_vld, output o_trc_rec, input  i_trc_rdy);
  modport slave  (input  o_trc_vld, input  o_trc_rec, output i_trc_rdy);
endinterface

// File: rtl/idli_trace_fifo_m.sv
// Synchronous FIFO with a registered head word; push and pop may share an edge.
module idli_trace_fifo_m #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rdy,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_head;
  logic             r_vld;

  logic        w_pop;
  logic        w_push;
  logic        w_full;
  logic [AW:0] w_wr_nxt;
  logic [AW:0] w_rd_nxt;

  assign w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop    = r_vld && i_rdy;
  assign w_push   = i_push && (!w_full || w_pop);
  assign w_wr_nxt = r_wr + (AW+1)'(w_push);
  assign w_rd_nxt = r_rd + (AW+1)'(w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= i_data;
    end
  end

  // Head is preloaded for the next cycle; bypass when the new head is being written now
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_vld  <= 1'b0;
      r_head <= '0;
    end else begin
      r_wr  <= w_wr_nxt;
      r_rd  <= w_rd_nxt;
      r_vld <= (w_wr_nxt != w_rd_nxt);
      if (w_wr_nxt == w_rd_nxt) begin
        r_head <= '0;
      end else if (w_push && (w_rd_nxt == r_wr)) begin
        r_head <= i_data;
      end else begin
        r_head <= r_mem[w_rd_nxt[AW-1:0]];
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_head;
  assign o_full = w_full;

endmodule

// File: rtl/idli_trace_m.sv
// In-core retire tracer: accumulates per-instruction effects on the sync counter
// and queues one record per retire, with PC trigger and overflow accounting.
module idli_trace_m
  import idli_pkg::*;
#(
  parameter int DEPTH = TRC_DEPTH
) (
  input  logic              i_trc_gck,
  input  logic              i_trc_rst,
  input  logic [1:0]        i_trc_ctr,
  input  logic              i_trc_run_instr,
  input  logic              i_trc_enc_new,
  input  logic [DATA_W-1:0] i_trc_pc,
  input  logic              i_trc_reg_wr,
  input  logic [REG_W-1:0]  i_trc_reg,
  input  logic              i_trc_pred_wr,
  input  logic              i_trc_pred,
  input  logic              i_trc_en,
  input  logic              i_trc_trig_en,
  input  logic [DATA_W-1:0] i_trc_trig_pc,
  idli_trace_if.master      trc,
  output logic [DROP_W-1:0] o_trc_drops,
  output logic              o_trc_ovf
);

  logic [DATA_W-1:0]   r_pc;
  logic [NUM_REGS-1:1] r_mask;
  logic                r_pred_wr;
  logic                r_pred_val;
  logic [SEQ_W-1:0]    r_seq;
  logic                r_lost;
  logic                r_trig;
  logic                r_ovf;
  logic [DROP_W-1:0]   r_drops;

  logic                w_first;
  logic                w_retire;
  logic                w_match;
  logic                w_gate;
  logic                w_full;
  logic                w_vld;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [NUM_REGS-1:0] w_reg_dec;
  trc_rec_t            w_rec;
  logic [$bits(trc_rec_t)-1:0] w_head;

  assign w_first   = (i_trc_ctr == 2'd0);
  assign w_retire  = (i_trc_ctr == CTR_LAST) && i_trc_run_instr;
  assign w_reg_dec = NUM_REGS'(1) << i_trc_reg;

  // The retire that hits the trigger PC is itself captured
  assign w_match = i_trc_trig_en && (r_pc == i_trc_trig_pc);
  assign w_gate  = i_trc_en && (!i_trc_trig_en || r_trig || w_match);
  assign w_pop   = w_vld && trc.i_trc_rdy;
  assign w_push  = w_retire && w_gate && (!w_full || w_pop);
  assign w_drop  = w_retire && w_gate && w_full && !w_pop;

  always_comb begin
    w_rec          = '0;
    w_rec.pc       = r_pc;
    w_rec.reg_mask = r_mask;
    w_rec.pred_wr  = r_pred_wr;
    w_rec.pred_val = r_pred_val;
    w_rec.seq      = r_seq;
    w_rec.lost     = r_lost;
  end

  always_ff @(posedge i_trc_gck) begin
    if (i_trc_rst) begin
      r_pc       <= '0;
      r_mask     <= '0;
      r_pred_wr  <= 1'b0;
      r_pred_val <= 1'b0;
      r_seq      <= '0;
      r_lost     <= 1'b0;
      r_trig     <= 1'b0;
      r_ovf      <= 1'b0;
      r_drops    <= '0;
    end else begin
      if (w_retire) begin
        r_mask     <= '0;
        r_pred_wr  <= 1'b0;
        r_pred_val <= 1'b0;
        r_seq      <= r_seq + 1'b1;
      end else if (w_first) begin
        if (i_trc_enc_new) begin
          r_pc <= i_trc_pc;
        end
        if (i_trc_reg_wr) begin
          r_mask <= r_mask | w_reg_dec[NUM_REGS-1:1];
        end
        if (i_trc_pred_wr) begin
          r_pred_wr  <= 1'b1;
          r_pred_val <= i_trc_pred;
        end
      end

      if (!i_trc_trig_en) begin
        r_trig <= 1'b0;
      end else if (w_retire && w_match) begin
        r_trig <= 1'b1;
      end

      if (w_drop) begin
        r_lost <= 1'b1;
        r_ovf  <= 1'b1;
        if (r_drops != '1) begin
          r_drops <= r_drops + 1'b1;
        end
      end else if (w_push) begin
        r_lost <= 1'b0;
      end
    end
  end

  idli_trace_fifo_m #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(trc_rec_t))
  ) u_fifo (
    .i_clk  (i_trc_gck),
    .i_rst  (i_trc_rst),
    .i_push (w_push),
    .i_data (w_rec),
    .i_rdy  (trc.i_trc_rdy),
    .o_vld  (w_vld),
    .o_data (w_head),
    .o_full (w_full)
  );

  assign trc.o_trc_vld = w_vld;
  assign trc.o_trc_rec = trc_rec_t'(w_head);
  assign o_trc_drops   = r_drops;
  assign o_trc_ovf     = r_ovf;

endmodule

// File: tb/tb_idli_trace_m.sv
// Bench for idli_trace_m: directed scenarios plus randomized retire traffic,
// checked every cycle against a queue-based model of the record stream.
module tb_idli_trace_m;
  import idli_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        ctr;
  logic              run;
  logic              enc;
  logic [DATA_W-1:0] pc;
  logic              rwr;
  logic [REG_W-1:0]  rg;
  logic              pwr;
  logic              pv;
  logic              en;
  logic              ten;
  logic [DATA_W-1:0] tpc;
  logic [DROP_W-1:0] drops;
  logic              ovf;
  bit                rand_rdy;

  always #5 clk = ~clk;

  idli_trace_if trc_if ();

  idli_trace_m dut (
    .i_trc_gck       (clk),
    .i_trc_rst       (rst),
    .i_trc_ctr       (ctr),
    .i_trc_run_instr (run),
    .i_trc_enc_new   (enc),
    .i_trc_pc        (pc),
    .i_trc_reg_wr    (rwr),
    .i_trc_reg       (rg),
    .i_trc_pred_wr   (pwr),
    .i_trc_pred      (pv),
    .i_trc_en        (en),
    .i_trc_trig_en   (ten),
    .i_trc_trig_pc   (tpc),
    .trc             (trc_if),
    .o_trc_drops     (drops),
    .o_trc_ovf       (ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: record stream as a bounded queue of whole records
  trc_rec_t            mq[$];
  logic [DATA_W-1:0]   e_pc;
  logic [NUM_REGS-1:1] e_mask;
  bit                  e_pwr, e_pv;
  int                  m_seq, m_drops;
  bit                  m_lost, m_trig, m_ovf;

  always @(posedge clk) begin : model
    bit       pop, match, gate;
    trc_rec_t r;
    if (rst) begin
      mq.delete();
      e_pc = '0; e_mask = '0; e_pwr = 0; e_pv = 0;
      m_seq = 0; m_drops = 0; m_lost = 0; m_trig = 0; m_ovf = 0;
    end else begin
      pop = (mq.size() != 0) && trc_if.i_trc_rdy;
      if (pop) void'(mq.pop_front());
      if (ctr == 2'd0) begin
        if (enc) e_pc = pc;
        if (rwr) e_mask = e_mask | 15'((32'd1 << rg) >> 1);
        if (pwr) begin e_pwr = 1; e_pv = pv; end
      end
      if (ctr == 2'd3 && run) begin
        match = ten && (e_pc == tpc);
        gate  = en && (!ten || m_trig || match);
        if (gate) begin
          r.pc = e_pc; r.reg_mask = e_mask; r.pred_wr = e_pwr; r.pred_val = e_pv;
          r.seq = SEQ_W'(m_seq); r.lost = m_lost;
          if (mq.size() < TRC_DEPTH) begin
            mq.push_back(r);
            m_lost = 0;
          end else begin
            if (m_drops < 255) m_drops++;
            m_ovf  = 1;
            m_lost = 1;
          end
        end
        m_seq = (m_seq + 1) % 256;
        e_mask = '0; e_pwr = 0; e_pv = 0;
        if (match) m_trig = 1;
      end
      if (!ten) m_trig = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("vld", 64'(trc_if.o_trc_vld), 64'(mq.size() != 0));
      if (mq.size() != 0) chk("rec", 64'(trc_if.o_trc_rec), 64'(mq[0]));
      chk("drops", 64'(drops), 64'(m_drops));
      chk("ovf", 64'(ovf), 64'(m_ovf));
    end
  end

  // One instruction period, entered and left at posedge+1
  task automatic instr(input logic [15:0] ipc, input bit ienc, input bit iwr,
                       input logic [3:0] ireg, input bit ipwr, input bit ipv,
                       input bit irun, input int rdy_last);
    for (int c = 0; c < 4; c++) begin
      ctr = 2'(c);
      run = irun;
      if (c == 0) begin
        enc = ienc; pc = ipc; rwr = iwr; rg = ireg; pwr = ipwr; pv = ipv;
      end else begin
        enc = 0; rwr = 0; pwr = 0;
        pc = 16'($urandom); rg = 4'($urandom); pv = 1'($urandom);
      end
      if (rand_rdy) trc_if.i_trc_rdy = 1'($urandom_range(0, 1));
      if (c == 3 && rdy_last >= 0) trc_if.i_trc_rdy = rdy_last[0];
      @(posedge clk); #1;
    end
    run = 0;
    if (rdy_last == 1) trc_if.i_trc_rdy = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    rst = 1; ctr = 2'd3; run = 0; enc = 0; pc = '0; rwr = 0; rg = '0;
    pwr = 0; pv = 0; en = 0; ten = 0; tpc = '0; rand_rdy = 0;
    trc_if.i_trc_rdy = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_vld", 64'(trc_if.o_trc_vld), 64'd0);
    chk("rst_rec", 64'(trc_if.o_trc_rec), 64'd0);
    chk("rst_drops", 64'(drops), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 0;

    // r3 write at 0x0010
    en = 1; trc_if.i_trc_rdy = 1;
    instr(16'h0010, 1, 1, 4'd3, 0, 0, 1, -1);
    @(negedge clk);
    chk("t1_vld", 64'(trc_if.o_trc_vld), 64'd1);
    chk("t1_pc", 64'(trc_if.o_trc_rec.pc), 64'h0010);
    chk("t1_mask", 64'({trc_if.o_trc_rec.reg_mask, 1'b0}), 64'h0008);
    chk("t1_seq", 64'(trc_if.o_trc_rec.seq), 64'd0);
    chk("t1_lost", 64'(trc_if.o_trc_rec.lost), 64'd0);

    // r0 write is invisible, predicate write is
    instr(16'h0012, 1, 1, 4'd0, 1, 1, 1, -1);
    @(negedge clk);
    chk("t2_mask", 64'(trc_if.o_trc_rec.reg_mask), 64'd0);
    chk("t2_pwr", 64'(trc_if.o_trc_rec.pred_wr), 64'd1);
    chk("t2_pv", 64'(trc_if.o_trc_rec.pred_val), 64'd1);

    // Overflow: 10 retires into 8 entries, then drain
    do_reset();
    trc_if.i_trc_rdy = 0;
    for (int i = 0; i < 10; i++) instr(16'h0100 + 16'(2*i), 1, 1, 4'(i+1), 0, 0, 1, -1);
    @(negedge clk);
    chk("t3_drops", 64'(drops), 64'd2);
    chk("t3_ovf", 64'(ovf), 64'd1);
    @(posedge clk); #1;
    trc_if.i_trc_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3_drain_seq", 64'(trc_if.o_trc_rec.seq), 64'(i));
    end
    @(posedge clk); #1;
    instr(16'h0200, 1, 0, 4'd0, 0, 0, 1, -1);
    @(negedge clk);
    chk("t3_next_seq", 64'(trc_if.o_trc_rec.seq), 64'd10);
    chk("t3_next_lost", 64'(trc_if.o_trc_rec.lost), 64'd1);

    // Full FIFO with a pop on the retire edge
    do_reset();
    trc_if.i_trc_rdy = 0;
    for (int i = 0; i < 8; i++) instr(16'h0300 + 16'(2*i), 1, 0, 4'd0, 0, 0, 1, -1);
    instr(16'h0310, 1, 0, 4'd0, 0, 0, 1, 1);
    @(negedge clk);
    chk("t4_drops", 64'(drops), 64'd0);
    chk("t4_ovf", 64'(ovf), 64'd0);
    chk("t4_head_seq", 64'(trc_if.o_trc_rec.seq), 64'd1);

    // PC trigger
    do_reset();
    trc_if.i_trc_rdy = 1; ten = 1; tpc = 16'h0040;
    instr(16'h0020, 1, 0, 4'd0, 0, 0, 1, -1);
    @(negedge clk);
    chk("t5_skip", 64'(trc_if.o_trc_vld), 64'd0);
    instr(16'h0040, 1, 0, 4'd0, 0, 0, 1, -1);
    @(negedge clk);
    chk("t5_hit_pc", 64'(trc_if.o_trc_rec.pc), 64'h0040);
    chk("t5_hit_seq", 64'(trc_if.o_trc_rec.seq), 64'd1);
    instr(16'h0042, 1, 0, 4'd0, 0, 0, 1, -1);
    @(negedge clk);
    chk("t5_after_pc", 64'(trc_if.o_trc_rec.pc), 64'h0042);
    ten = 0;

    // Sequence wrap and reset with queued records
    do_reset();
    trc_if.i_trc_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      instr(16'(2*i), 1, 0, 4'd0, 0, 0, 1, -1);
      if (i == 255 || i == 256) begin
        @(negedge clk);
        chk("t6_wrap_seq", 64'(trc_if.o_trc_rec.seq), (i == 255) ? 64'd255 : 64'd0);
      end
    end
    trc_if.i_trc_rdy = 0;
    for (int i = 0; i < 3; i++) instr(16'h0500, 1, 0, 4'd0, 0, 0, 1, -1);
    @(negedge clk);
    chk("t6_queued", 64'(trc_if.o_trc_vld), 64'd1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk("t6_rst_vld", 64'(trc_if.o_trc_vld), 64'd0);
    chk("t6_rst_rec", 64'(trc_if.o_trc_rec), 64'd0);
    rst = 0;
    trc_if.i_trc_rdy = 1;
    instr(16'h0600, 1, 0, 4'd0, 0, 0, 1, -1);
    @(negedge clk);
    chk("t6_seq_restart", 64'(trc_if.o_trc_rec.seq), 64'd0);

    // Randomized traffic with trigger toggling and back-pressure
    rand_rdy = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) ten = ~ten;
      if ($urandom_range(0, 29) == 0) tpc = 16'h0100 + 16'(2 * $urandom_range(0, 7));
      en = ($urandom_range(0, 9) != 0);
      instr(16'h0100 + 16'(2 * $urandom_range(0, 7)), 1'($urandom), 1'($urandom),
            4'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 6) != 0), -1);
    end
    rand_rdy = 0;
    trc_if.i_trc_rdy = 1;
    repeat (12) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
